enqueue_agent_v0_2: RTL
=======================

Name: enqueue_agent_v0_2

Overview:
Parametrised successor of the v0_1 enqueue agent; sits between the output pipeline and the per-port packet buffers and PIFOs.
- Decodes destination and source one-hot fields from the SUME metadata on the first beat (SOP) of each packet.
- Masks destinations whose buffer is almost full or whose PIFO is full, and holds that decision for the whole packet.
- New versus v0_1: port count, metadata positions and counter width are parametrised; an all-or-nothing drop mode; a separate policy-drop counter column; optional clear-on-read of the CPU-visible drop counters.

Parameters:
NUM_PHY_PORTS, 4, physical ports; queue count NQ = NUM_PHY_PORTS+1, and queue NQ-1 is the CPU queue.
META_W, 128, tuser width.
SRC_POS, 16, LSB of src field (2 bits per physical port: even bit = phy, odd bit = CPU).
DST_POS, 24, LSB of dst field (same layout as src).
DROP_POS, 32, policy-drop bit position.
CNT_W, 32, drop counter width.
DROP_MODE, 0, 0 = partial delivery; 1 = all-or-nothing.
CLR_ON_READ, 0, 1 = a CPU read clears the addressed counter.

Ports:
axis_aclk  in  1  clock
axis_resetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  pipeline beat valid
s_axis_tready  out  1  agent ready
s_axis_tuser  in  META_W  sume_meta
s_axis_tlast  in  1  last beat of packet
s_axis_buffer_almost_full  in  NQ  per-queue buffer almost-full
s_axis_pifo_full  in  NQ  per-queue PIFO full
m_axis_ctl_buffer_wr_en  out  NQ  per-queue buffer write enable, per accepted beat
m_axis_ctl_pifo_in_en  out  NQ  per-queue PIFO insert, one pulse per packet
s_axi_addr  in  8  {src[3:0], dst[3:0]} counter select
s_axi_req_valid  in  1  CPU read request
m_axi_data  out  32  counter value, zero-extended or truncated from CNT_W
m_axi_resp_valid  out  1  CPU response valid

Behaviour:
- Clocking and reset: single clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; held mask 0; all counters 0.
- s_axis_tready: registered; 0 in reset, 1 from the first edge after reset release. No other backpressure.
- A beat is accepted when tvalid & tready.
- FSM states:
  - IDLE → PKT on an accepted beat with tlast=0.
  - IDLE stays IDLE on an accepted single-beat packet (tlast=1).
  - PKT → IDLE on an accepted beat with tlast=1.
- Destination mask: req[i] = tuser[DST_POS+2i] for i < NUM_PHY_PORTS. req[NQ-1] = OR of all odd dst bits.
- Full status: full = buffer_almost_full | pifo_full.
- Decision, evaluated combinationally on the SOP beat (any accepted beat in IDLE):
  - Policy drop (tuser[DROP_POS]=1): mask = 0.
  - DROP_MODE=0: mask = req & ~full.
  - DROP_MODE=1: mask = req if (req & full) == 0, else 0.
- Mask hold: mask is latched at SOP and used for every later beat. Full-status changes mid-packet are ignored.
- Write outputs:
  - buffer_wr_en = mask on every accepted beat, combinational on the SOP beat.
  - pifo_in_en = mask on the accepted tlast beat only.
  - Both outputs are 0 whenever no beat is accepted.
- Source index: lowest set even bit of the src field; an odd bit maps to the same port index. If no src bit is set, counters are not updated.
- Counters:
  - Array [NUM_PHY_PORTS][NQ+1] of CNT_W, updated once per packet at SOP.
  - cnt[src][q] += 1 for each q with req[q] & ~mask[q], excluding policy drops.
  - A policy drop increments only cnt[src][NQ].
  - Counters saturate at all-ones.
- CPU read:
  - m_axi_resp_valid pulses 1 cycle after s_axi_req_valid. m_axi_data holds the counter sampled at the request edge.
  - An out-of-range address returns 0.
  - With CLR_ON_READ=1 and an increment of the same counter in the same cycle: the read returns the old value and the counter becomes 1.
- Reset mid-packet: return to IDLE and clear the mask. The next accepted beat is treated as SOP.
- tvalid low mid-packet: state and mask are held.

Test Plan:
- Reset: drive axis_resetn=0 for 20 cycles → tready=0 and all enables 0. After release, tready=1 on the next edge.
- Partial delivery, DROP_MODE=0: dst ports 0 and 3, buffer_almost_full=5'b01110, 2 beats → buffer_wr_en=5'b00001 on both beats, pifo_in_en=5'b00001 on beat 2 only, cnt[0][3]=1.
- All-or-nothing, DROP_MODE=1: dst ports 1/2/3, src port 1, pifo_full=5'b00010, 3 beats → all enables 0, cnt[1][1]=cnt[1][2]=cnt[1][3]=1. Reads of addr 0x11/0x12/0x13 return 1 one cycle after each request.
- Mid-packet full change: dst ports 1/2/3 with nothing full at SOP, then set buffer_almost_full=5'b01110 on beat 2 → buffer_wr_en=5'b01110 on all 3 beats.
- CPU and policy drop: dst bits DST_POS+1 and DST_POS+3 → mask=5'b10000. Next, a packet with DROP_POS=1 and dst ports 0/1/2 from src 0 → no enables, cnt[0][5]=1, other counters in row 0 unchanged.
- Counter boundary with CNT_W=4, CLR_ON_READ=1: 16 drops to [0][0] → counter reads 15 (saturated). Read coinciding with an increment → returns 15, the next read returns 1.

Source files
------------

// File: rtl/enqueue_agent_v0_2.sv
// Enqueue agent: decodes SUME metadata at SOP, masks full or policy-dropped destinations for the
// whole packet, drives per-queue buffer/PIFO enables and keeps CPU-readable per-source drop counters.
module enqueue_agent_v0_2 #(
    parameter int NUM_PHY_PORTS = 4,
    parameter int META_W        = 128,
    parameter int SRC_POS       = 16,
    parameter int DST_POS       = 24,
    parameter int DROP_POS      = 32,
    parameter int CNT_W         = 32,
    parameter int DROP_MODE     = 0,
    parameter int CLR_ON_READ   = 0
) (
    input  logic                     axis_aclk,
    input  logic                     axis_resetn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [META_W-1:0]        s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic [NUM_PHY_PORTS:0]   s_axis_buffer_almost_full,
    input  logic [NUM_PHY_PORTS:0]   s_axis_pifo_full,
    output logic [NUM_PHY_PORTS:0]   m_axis_ctl_buffer_wr_en,
    output logic [NUM_PHY_PORTS:0]   m_axis_ctl_pifo_in_en,
    input  logic [7:0]               s_axi_addr,
    input  logic                     s_axi_req_valid,
    output logic [31:0]              m_axi_data,
    output logic                     m_axi_resp_valid
);

    localparam int NQ = NUM_PHY_PORTS + 1;

    typedef enum logic {IDLE, PKT} state_t;

    state_t                state_q, state_d;
    logic [NQ-1:0]         mask_q, mask_d;
    logic                  tready_q;
    logic                  resp_valid_q;
    logic [31:0]           data_q;
    logic [CNT_W-1:0]      cnt_q [NUM_PHY_PORTS][NQ+1];

    logic                  accept, sop, policy;
    logic [NQ-1:0]         req, full, mask_sop, mask_use;
    logic [NUM_PHY_PORTS-1:0] src_sel;
    logic [NQ:0]           inc_col;
    logic [31:0]           rd_src_w, rd_q_w;
    logic [CNT_W-1:0]      rd_val;
    logic                  unused_tuser;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic clr, input logic inc);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != {CNT_W{1'b1}}))
            base = base + CNT_W'(1);
        return base;
    endfunction

    function automatic logic [31:0] to_word(input logic [CNT_W-1:0] v);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < CNT_W && b < 32; b++)
            r[b] = v[b];
        return r;
    endfunction

    assign unused_tuser = ^s_axis_tuser;
    assign accept       = s_axis_tvalid & tready_q;
    assign sop          = accept & (state_q == IDLE);
    assign policy       = s_axis_tuser[DROP_POS];
    assign full         = s_axis_buffer_almost_full | s_axis_pifo_full;

    // CPU queue is requested by any odd (CPU-side) destination bit
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PHY_PORTS; i++) begin
            req[i]    = s_axis_tuser[DST_POS + 2*i];
            req[NQ-1] = req[NQ-1] | s_axis_tuser[DST_POS + 2*i + 1];
        end
    end

    // Lowest port with either src bit set wins; no bit set leaves counters untouched
    always_comb begin
        src_sel = '0;
        for (int i = NUM_PHY_PORTS-1; i >= 0; i--) begin
            if (s_axis_tuser[SRC_POS + 2*i] | s_axis_tuser[SRC_POS + 2*i + 1]) begin
                src_sel    = '0;
                src_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        mask_sop = '0;
        if (!policy) begin
            if (DROP_MODE == 0)
                mask_sop = req & ~full;
            else if ((req & full) == '0)
                mask_sop = req;
        end
    end

    assign mask_use = (state_q == IDLE) ? mask_sop : mask_q;

    always_comb begin
        inc_col = '0;
        if (sop && (src_sel != '0)) begin
            if (policy)
                inc_col[NQ] = 1'b1;
            else
                inc_col[NQ-1:0] = req & ~mask_sop;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        m_axis_ctl_buffer_wr_en = '0;
        m_axis_ctl_pifo_in_en   = '0;
        if (accept) begin
            m_axis_ctl_buffer_wr_en = mask_use;
            if (s_axis_tlast)
                m_axis_ctl_pifo_in_en = mask_use;
            if (state_q == IDLE) begin
                mask_d  = mask_sop;
                state_d = s_axis_tlast ? IDLE : PKT;
            end else if (s_axis_tlast) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            tready_q <= 1'b1;
        end
    end

    assign rd_src_w = 32'(s_axi_addr[7:4]);
    assign rd_q_w   = 32'(s_axi_addr[3:0]);

    // Address decode by match so that out-of-range selects simply read as zero
    always_comb begin
        rd_val = '0;
        for (int s = 0; s < NUM_PHY_PORTS; s++)
            for (int q = 0; q <= NQ; q++)
                if ((rd_src_w == 32'(s)) && (rd_q_w == 32'(q)))
                    rd_val = cnt_q[s][q];
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int s = 0; s < NUM_PHY_PORTS; s++)
                for (int q = 0; q <= NQ; q++)
                    cnt_q[s][q] <= '0;
        end else begin
            for (int s = 0; s < NUM_PHY_PORTS; s++)
                for (int q = 0; q <= NQ; q++)
                    cnt_q[s][q] <= cnt_next(cnt_q[s][q],
                        (CLR_ON_READ != 0) && s_axi_req_valid &&
                        (rd_src_w == 32'(s)) && (rd_q_w == 32'(q)),
                        src_sel[s] & inc_col[q]);
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            resp_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            resp_valid_q <= s_axi_req_valid;
            if (s_axi_req_valid)
                data_q <= to_word(rd_val);
        end
    end

    assign s_axis_tready    = tready_q;
    assign m_axi_resp_valid = resp_valid_q;
    assign m_axi_data       = data_q;

endmodule
